// File: rtl/conv_deinterleaver_if.sv
// Byte-stream bundle for the convolutional deinterleaver: input byte/valid/sync and registered outputs.
// Latency: none (wires only).
// Backpressure: none; there is no ready signal, so the sink must take every valid byte.
interface conv_deinterleaver_if #(
    parameter int W = 8
);
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         sync_in;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         sync_out;
    logic         sync_err;

    modport master (
        output data_in, valid_in, sync_in,
        input  data_out, valid_out, sync_out, sync_err
    );

    modport slave (
        input  data_in, valid_in, sync_in,
        output data_out, valid_out, sync_out, sync_err
    );
endinterface

// File: rtl/conv_deinterleaver.sv
// Forney convolutional byte deinterleaver: branch j delays its bytes by (I-1-j)*M branch visits.
// Latency: 1 clk from the accepting edge to data_out/valid_out/sync_out/sync_err.
// Backpressure: none; a byte can be accepted on every cycle.
module conv_deinterleaver #(
    parameter int I = 12,
    parameter int M = 17,
    parameter int W = 8
) (
    input logic                 clk,
    input logic                 reset,
    conv_deinterleaver_if.slave s
);
    localparam int NCELL = M * I * (I - 1) / 2;
    localparam int AW    = $clog2(NCELL + 1);
    localparam int PW    = $clog2((I - 1) * M + 1);
    localparam int BW    = $clog2(I);

    logic [BW-1:0] b;
    logic [BW-1:0] t;
    logic          last;
    logic [PW-1:0] ptr [I-1];
    logic [I-2:0]  filled;
    logic [PW-1:0] ptr_cur;
    logic          ptr_end;
    logic          filled_cur;
    logic [AW-1:0] base;
    logic [AW-1:0] addr;
    logic [W-1:0]  mem [NCELL];

    logic [W-1:0]  dout_q;
    logic          vout_q;
    logic          sout_q;
    logic          serr_q;

    // All branches share one flat array; branch t starts after the cells of branches 0..t-1.
    always_comb begin
        t          = s.sync_in ? '0 : b;
        last       = (t == BW'(I - 1));
        base       = '0;
        ptr_cur    = '0;
        ptr_end    = 1'b0;
        filled_cur = 1'b0;
        for (int k = 0; k < I - 1; k++) begin
            if (BW'(k) < t) begin
                base = base + AW'((I - 1 - k) * M);
            end
            if (BW'(k) == t) begin
                ptr_cur    = ptr[k];
                ptr_end    = (ptr[k] == PW'((I - 1 - k) * M - 1));
                filled_cur = filled[k];
            end
        end
        addr = base + AW'(ptr_cur);
    end

    // Cells are never cleared; the per-branch fill flag makes unwritten cells read as zero.
    always_ff @(posedge clk) begin
        if (!reset && s.valid_in && !last) begin
            mem[addr] <= s.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b      <= '0;
            filled <= '0;
            dout_q <= '0;
            vout_q <= 1'b0;
            sout_q <= 1'b0;
            serr_q <= 1'b0;
            for (int k = 0; k < I - 1; k++) begin
                ptr[k] <= '0;
            end
        end else begin
            vout_q <= s.valid_in;
            sout_q <= s.valid_in & s.sync_in;
            serr_q <= s.valid_in & s.sync_in & (b != '0);
            if (s.valid_in) begin
                b <= last ? '0 : t + BW'(1);
                if (last) begin
                    dout_q <= s.data_in;
                end else begin
                    dout_q <= filled_cur ? mem[addr] : '0;
                    for (int k = 0; k < I - 1; k++) begin
                        if (BW'(k) == t) begin
                            ptr[k] <= ptr_end ? '0 : ptr[k] + PW'(1);
                            if (ptr_end) begin
                                filled[k] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign s.data_out  = dout_q;
    assign s.valid_out = vout_q;
    assign s.sync_out  = sout_q;
    assign s.sync_err  = serr_q;
endmodule
